// File: rtl/cmp_seq.sv
// Multi-cycle MSB-first chunked magnitude comparator with valid/ready on both sides.
// Optional macro CMP_SEQ_EARLY_EXIT_EN: finish the scan on the first differing slice.
module cmp_seq #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             sgn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       res,
    output logic             busy
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NCHUNK - 1);

`ifdef CMP_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    if (CHUNK == 0 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_err
        $error("cmp_seq: WIDTH must be a non-zero multiple of CHUNK");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             found_q, found_d;
    logic [1:0]       code_q, code_d;
    logic [1:0]       res_q, res_d;
    logic             out_valid_q, out_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;

    logic [CHUNK-1:0] slice_a, slice_b;
    logic             slice_diff;
    logic             done_now;

    // Sign bit flip turns two's-complement order into plain unsigned order.
    logic [WIDTH-1:0] sgn_mask;
    assign sgn_mask = WIDTH'(sgn) << (WIDTH - 1);

    assign slice_a    = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign slice_b    = b_q[int'(idx_q) * CHUNK +: CHUNK];
    assign slice_diff = (slice_a != slice_b);
    assign done_now   = (idx_q == '0) || (EARLY && slice_diff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            found_q     <= 1'b0;
            code_q      <= 2'b00;
            res_q       <= 2'b00;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            found_q     <= found_d;
            code_q      <= code_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        idx_d       = idx_q;
        found_d     = found_q;
        code_d      = code_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;

        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_ready_q && in_valid) begin
                        a_d     = op1 ^ sgn_mask;
                        b_d     = op2 ^ sgn_mask;
                        idx_d   = IDX_TOP;
                        found_d = 1'b0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    // First differing slice from the top decides; later ones are ignored.
                    if (slice_diff && !found_q) begin
                        found_d = 1'b1;
                        code_d  = (slice_a > slice_b) ? 2'b01 : 2'b10;
                    end
                    if (done_now) begin
                        state_d     = S_DONE;
                        res_d       = found_d ? code_d : 2'b11;
                        out_valid_d = 1'b1;
                    end else begin
                        idx_d = idx_q - IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end

        in_ready_d = (state_d == S_IDLE);
        busy_d     = (state_d != S_IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cmp_seq.sv
// Directed table-driven bench for cmp_seq (WIDTH=64, CHUNK=8), plus backpressure/flush/reset sequences.
module tb_cmp_seq;

    localparam int WIDTH  = 64;
    localparam int CHUNK  = 8;
    localparam int NCHUNK = WIDTH / CHUNK;
`ifdef CMP_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op1, op2;
    logic             sgn;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       res;
    logic             busy;

    int errors = 0;
    int checks = 0;

    cmp_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .sgn       (sgn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic [1:0]  r;
        int          k;   // 1-based position of deciding slice from the top; NCHUNK if equal
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(input int k);
        return EARLY ? (k + 1) : (NCHUNK + 1);
    endfunction

    // Presents one request, then waits (out_ready low) for the result; lat counts cycles after accept.
    task automatic do_txn(input logic [63:0] a, input logic [63:0] b, input logic s,
                          output logic [1:0] r, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        op1 = a; op2 = b; sgn = s; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; op1 = ~a; op2 = ~b; sgn = ~s;
        lat = -1;
        r   = 2'b00;
        for (int n = 1; n <= 40; n++) begin
            if (out_valid) begin
                lat = n;
                r   = res;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_in_ready_after"}, 64'(in_ready), 64'd1);
        chk({name, "_out_valid_drop"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        logic [1:0] r;
        int         lat;
        int         seen;

        vecs[0] = '{"u_msb_vs_1",    64'h8000_0000_0000_0000, 64'h1,                    1'b0, 2'b01, 1};
        vecs[1] = '{"s_msb_vs_1",    64'h8000_0000_0000_0000, 64'h1,                    1'b1, 2'b10, 1};
        vecs[2] = '{"u_equal",       64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001,  1'b0, 2'b11, 8};
        vecs[3] = '{"u_0_vs_1",      64'h0,                   64'h1,                    1'b0, 2'b10, 8};
        vecs[4] = '{"s_m1_vs_0",     64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                    1'b1, 2'b10, 1};
        vecs[5] = '{"u_max_vs_0",    64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                    1'b0, 2'b01, 1};
        vecs[6] = '{"u_slice3",      64'h0000_0100_0000_0000, 64'h0000_0200_0000_0000,  1'b0, 2'b10, 3};
        vecs[7] = '{"u_no_overwr",   64'h0000_0000_0100_00FF, 64'h0000_0000_0200_0000,  1'b0, 2'b10, 5};
        vecs[8] = '{"s_min_vs_m1",   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,  1'b1, 2'b10, 1};
        vecs[9] = '{"s_5_vs_3",      64'h5,                   64'h3,                    1'b1, 2'b01, 8};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        op1 = 64'h1234; op2 = 64'h0; sgn = 1'b0;

        // Reset held with in_valid high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_in_ready",  64'(in_ready),  64'd0);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_res",       64'(res),       64'd0);
            chk("rst_busy",      64'(busy),      64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_busy",     64'(busy),     64'd0);
        in_valid = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            do_txn(vecs[i].a, vecs[i].b, vecs[i].s, r, lat);
            chk({vecs[i].name, "_res"}, 64'(r), 64'(vecs[i].r));
            chk({vecs[i].name, "_lat"}, 64'(lat), 64'(exp_lat(vecs[i].k)));
            chk({vecs[i].name, "_busy"}, 64'(busy), 64'd1);
            release_out(vecs[i].name);
        end

        // Backpressure: result held while out_ready is low
        do_txn(64'h8000_0000_0000_0000, 64'h1, 1'b0, r, lat);
        chk("bp_res0", 64'(r), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_res",       64'(res),       64'd1);
            chk("bp_in_ready",  64'(in_ready),  64'd0);
        end
        release_out("bp");
        do_txn(64'h0, 64'h1, 1'b0, r, lat);
        chk("bp_next_res", 64'(r), 64'd2);
        chk("bp_next_lat", 64'(lat), 64'(exp_lat(8)));
        release_out("bp_next");

        // Flush on the 3rd RUN cycle; res must keep 2'b01 from the prior result
        do_txn(64'h8000_0000_0000_0000, 64'h1, 1'b0, r, lat);
        chk("fl_prior_res", 64'(r), 64'd1);
        release_out("fl_prior");
        op1 = 64'h0; op2 = 64'h1; sgn = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_busy",      64'(busy),      64'd0);
        chk("fl_in_ready",  64'(in_ready),  64'd1);
        chk("fl_out_valid", 64'(out_valid), 64'd0);
        chk("fl_res_kept",  64'(res),       64'd1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("fl_no_result", 64'(seen), 64'd0);
        do_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, r, lat);
        chk("fl_next_res", 64'(r), 64'd2);
        chk("fl_next_lat", 64'(lat), 64'(exp_lat(1)));
        release_out("fl_next");

        // Request presented together with flush in IDLE is dropped
        op1 = 64'h5; op2 = 64'h3; sgn = 1'b0; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("fl_idle_busy",     64'(busy),     64'd0);
        chk("fl_idle_in_ready", 64'(in_ready), 64'd1);

        // Asynchronous reset in the middle of RUN
        op1 = 64'h0; op2 = 64'h1; sgn = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mr_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_busy",      64'(busy),      64'd0);
        chk("mr_in_ready",  64'(in_ready),  64'd0);
        chk("mr_out_valid", 64'(out_valid), 64'd0);
        chk("mr_res",       64'(res),       64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("mr_no_result",   64'(seen),     64'd0);
        chk("mr_in_ready_up", 64'(in_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
